spike_decoder: RTL and testbench

Register-mapped spike train decoder peripheral for the TinyQV peripheral harness, the receive-side counterpart to the spike encoder. It takes a spike train on `ui_in[0]`, synchronizes it, and detects rising edges. From those edges it produces two measurements: a rate code (spike count per programmable window) and an inter-spike interval (ISI). A decoded level is set by comparing the last rate against a threshold, and is driven on `uo_out` and readable through the register port.

---
 rtl/spike_decoder_if.sv | 19 +
 rtl/spike_decoder.sv | 178 +++++++++++++++++
 tb/tb_spike_decoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_decoder_if.sv
// Register-port and pad bundle for the spike decoder peripheral.
interface spike_decoder_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output ui_in, address, data_write, data_in,
    input  uo_out, data_out
  );

  modport slave (
    input  ui_in, address, data_write, data_in,
    output uo_out, data_out
  );
endinterface

// File: rtl/spike_decoder.sv
// Spike train decoder: synchronizes ui_in[0], detects rising edges, and
// measures spike rate per window and inter-spike interval. The decoded level
// is RATE >= THRESH, latched at each window close.
module spike_decoder (
  input  logic            clk,
  input  logic            rst_n,
  spike_decoder_if.slave  bus
);

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_WINDOW = 4'h1;
  localparam logic [3:0] ADDR_THRESH = 4'h2;
  localparam logic [3:0] ADDR_RATE   = 4'h3;
  localparam logic [3:0] ADDR_ISI    = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h5;
  localparam logic [3:0] ADDR_LIVE   = 4'h6;

  // Input path
  logic sync1_q, sync2_q, prev_q;
  logic edge_det;

  // Architectural state
  logic       en_q,     en_d;
  logic [7:0] window_q, window_d;
  logic [7:0] thresh_q, thresh_d;
  logic [7:0] rate_q,   rate_d;
  logic [7:0] isi_q,    isi_d;
  logic       valid_q,  valid_d;
  logic       level_q,  level_d;
  logic       armed_q,  armed_d;
  logic [7:0] live_q,   live_d;
  logic [7:0] wcnt_q,   wcnt_d;
  logic [7:0] isicnt_q, isicnt_d;
  logic       done_q,   done_d;
  logic       edge_q,   edge_d;

  // Decode helpers
  logic       wr_ctrl, wr_window, wr_thresh, wr_status;
  logic       clr;
  logic       close;
  logic [7:0] live_next;

  logic unused_ui;
  assign unused_ui = ^bus.ui_in[7:1];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizer plus previous-value flop; runs regardless of EN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.ui_in[0];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det  = sync2_q & ~prev_q;
  assign wr_ctrl   = bus.data_write && (bus.address == ADDR_CTRL);
  assign wr_window = bus.data_write && (bus.address == ADDR_WINDOW);
  assign wr_thresh = bus.data_write && (bus.address == ADDR_THRESH);
  assign wr_status = bus.data_write && (bus.address == ADDR_STATUS);
  assign clr       = wr_ctrl & bus.data_in[1];

  // Next-state: counting, window close, ISI capture, clear and register writes.
  always_comb begin
    en_d      = en_q;
    window_d  = window_q;
    thresh_d  = thresh_q;
    rate_d    = rate_q;
    isi_d     = isi_q;
    valid_d   = valid_q;
    level_d   = level_q;
    armed_d   = armed_q;
    live_d    = live_q;
    wcnt_d    = wcnt_q;
    isicnt_d  = isicnt_q;
    done_d    = 1'b0;
    edge_d    = edge_det;
    close     = 1'b0;
    live_next = edge_det ? sat_inc(live_q) : live_q;

    if (wr_ctrl)   en_d     = bus.data_in[0];
    if (wr_window) window_d = bus.data_in;
    if (wr_thresh) thresh_d = bus.data_in;

    if (clr) begin
      wcnt_d   = '0;
      live_d   = '0;
      isicnt_d = '0;
      rate_d   = '0;
      isi_d    = '0;
      valid_d  = 1'b0;
      level_d  = 1'b0;
      armed_d  = 1'b0;
    end else if (en_q) begin
      close    = (wcnt_q >= window_q);
      isicnt_d = sat_inc(isicnt_q);
      if (edge_det) begin
        // isicnt_q holds cycles-1 since the previous edge, hence the +1.
        if (armed_q) isi_d = sat_inc(isicnt_q);
        armed_d  = 1'b1;
        isicnt_d = '0;
      end
      if (close) begin
        // The edge on the closing cycle belongs to the closing window.
        rate_d  = live_next;
        live_d  = '0;
        wcnt_d  = '0;
        valid_d = 1'b1;
        level_d = (live_next >= thresh_q);
        done_d  = 1'b1;
      end else begin
        live_d = live_next;
        wcnt_d = wcnt_q + 8'd1;
      end
    end

    // A window close in the same cycle outranks the write-1-to-clear.
    if (wr_status && bus.data_in[0] && !close) valid_d = 1'b0;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      window_q <= 8'd99;
      thresh_q <= 8'd10;
      rate_q   <= '0;
      isi_q    <= '0;
      valid_q  <= 1'b0;
      level_q  <= 1'b0;
      armed_q  <= 1'b0;
      live_q   <= '0;
      wcnt_q   <= '0;
      isicnt_q <= '0;
      done_q   <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      window_q <= window_d;
      thresh_q <= thresh_d;
      rate_q   <= rate_d;
      isi_q    <= isi_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      armed_q  <= armed_d;
      live_q   <= live_d;
      wcnt_q   <= wcnt_d;
      isicnt_q <= isicnt_d;
      done_q   <= done_d;
      edge_q   <= edge_d;
    end
  end

  assign bus.uo_out = {5'b0, edge_q, done_q, level_q};

  // Combinational register read mux.
  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_CTRL:   bus.data_out = {7'b0, en_q};
      ADDR_WINDOW: bus.data_out = window_q;
      ADDR_THRESH: bus.data_out = thresh_q;
      ADDR_RATE:   bus.data_out = rate_q;
      ADDR_ISI:    bus.data_out = isi_q;
      ADDR_STATUS: bus.data_out = {5'b0, armed_q, level_q, valid_q};
      ADDR_LIVE:   bus.data_out = live_q;
      default:     bus.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder with a cycle-indexed reference model.
module tb_spike_decoder;

  logic clk;
  logic rst_n;
  spike_decoder_if bus_i ();

  spike_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;
  bit cmp_on  = 0;

  // Spike generator state, advanced once per cycle by cyc().
  int spk_period = 0;
  int spk_ph     = 0;
  bit spk_level  = 0;

  // Reference model: edges from the sampled-input history, counts kept as
  // plain integers indexed by enabled cycles.
  bit hist[$];
  int m_en, m_window, m_thresh, m_rate, m_isi, m_valid, m_level, m_armed;
  int m_live, en_cyc, win_start, last_edge;
  bit m_edge, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [3:0] a);
    case (a)
      4'h0: return 8'(m_en);
      4'h1: return 8'(m_window);
      4'h2: return 8'(m_thresh);
      4'h3: return 8'(m_rate);
      4'h4: return 8'(m_isi);
      4'h5: return 8'((m_armed << 2) | (m_level << 1) | m_valid);
      4'h6: return 8'((m_live > 255) ? 255 : m_live);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    bit e, close, clr;
    if (!rst_n) begin
      hist = '{1'b0, 1'b0, 1'b0};
      m_en = 0; m_window = 99; m_thresh = 10; m_rate = 0; m_isi = 0;
      m_valid = 0; m_level = 0; m_armed = 0; m_live = 0;
      win_start = en_cyc; m_edge = 0; m_done = 0;
    end else begin
      // An input high at cycle k-2 after low at k-3 is an edge at cycle k.
      e = hist[1] & ~hist[2];
      hist.push_front(bus_i.ui_in[0]);
      hist.delete(3);
      clr = bus_i.data_write && (bus_i.address == 4'h0) && bus_i.data_in[1];
      close = 0;
      m_edge = e;
      m_done = 0;
      if (clr) begin
        m_rate = 0; m_isi = 0; m_valid = 0; m_level = 0; m_armed = 0; m_live = 0;
        win_start = en_cyc;
      end else if (m_en != 0) begin
        close = (en_cyc - win_start) >= m_window;
        en_cyc++;
        if (e) begin
          if (m_armed != 0) m_isi = (en_cyc - last_edge > 255) ? 255 : en_cyc - last_edge;
          m_armed = 1;
          last_edge = en_cyc;
          m_live++;
        end
        if (close) begin
          m_rate = (m_live > 255) ? 255 : m_live;
          m_live = 0;
          win_start = en_cyc;
          m_valid = 1;
          m_level = (m_rate >= m_thresh) ? 1 : 0;
          m_done = 1;
        end
      end
      if (bus_i.data_write) begin
        case (bus_i.address)
          4'h0: m_en = int'(bus_i.data_in[0]);
          4'h1: m_window = int'(bus_i.data_in);
          4'h2: m_thresh = int'(bus_i.data_in);
          4'h5: if (bus_i.data_in[0] && !close) m_valid = 0;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of the registered pad outputs.
  always @(negedge clk) begin
    if (cmp_on) chk("uo_out_model", {24'b0, bus_i.uo_out}, {29'b0, m_edge, m_done, m_level[0]});
  end

  task automatic cyc();
    @(negedge clk);
    if (spk_period > 0) begin
      bus_i.ui_in = {7'h55, spk_ph == 0};
      spk_ph = (spk_ph + 1) % spk_period;
    end else begin
      bus_i.ui_in = {7'h55, spk_level};
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus_i.address    = a;
    bus_i.data_in    = d;
    bus_i.data_write = 1'b1;
    cyc();
    bus_i.data_write = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp, input string nm);
    bus_i.address = a;
    #1;
    chk(nm, {24'b0, bus_i.data_out}, {24'b0, exp});
    chk({nm, "_model"}, {24'b0, bus_i.data_out}, {24'b0, model_reg(a)});
  endtask

  task automatic uo_chk(input logic [7:0] exp, input string nm);
    #1;
    chk(nm, {24'b0, bus_i.uo_out}, {24'b0, exp});
  endtask

  task automatic check_reset_values(input string tag);
    logic [7:0] rv [8];
    rv = '{8'h00, 8'd99, 8'd10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    uo_chk(8'h00, {tag, "_uo"});
    for (int i = 0; i < 8; i++) rd_chk(4'(i), rv[i], $sformatf("%s_reg%0d", tag, i));
  endtask

  initial begin
    int n;
    bit seen;
    int pulses;

    rst_n = 1'b0;
    bus_i.ui_in = '0;
    bus_i.address = '0;
    bus_i.data_write = 1'b0;
    bus_i.data_in = '0;
    en_cyc = 0;
    last_edge = 0;
    repeat (3) cyc();
    cmp_on = 1;
    rst_n = 1'b1;

    // Reset values
    check_reset_values("reset");

    // Rate: WINDOW=19, THRESH=5, 1-high/3-low spikes
    wr(4'h1, 8'd19);
    wr(4'h2, 8'd5);
    spk_period = 4; spk_ph = 0;
    run(8);
    wr(4'h0, 8'h01);
    run(70);
    rd_chk(4'h3, 8'd5, "rate5");
    rd_chk(4'h5, 8'h07, "status_rate");
    rd_chk(4'h4, 8'd4, "isi_period4");

    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(); #1;
      if (bus_i.uo_out[1]) begin seen = 1; break; end
    end
    n = 0;
    if (seen) begin
      for (int i = 0; i < 40; i++) begin
        cyc(); #1;
        n++;
        if (bus_i.uo_out[1]) break;
      end
    end
    chk("done_pulse_period", n, 20);

    wr(4'h2, 8'd6);
    run(45);
    rd_chk(4'h5, 8'h05, "level_after_thresh6");
    rd_chk(4'h3, 8'd5, "rate_after_thresh6");

    // Edge on the closing cycle counts in the closing window
    spk_period = 0; spk_level = 0;
    run(5);
    wr(4'h1, 8'd9);
    wr(4'h0, 8'h03);
    run(6);
    spk_level = 1;
    cyc();
    spk_level = 0;
    cyc();
    run(2);
    uo_chk(8'h06, "close_edge_uo");
    rd_chk(4'h3, 8'd1, "close_edge_rate");
    rd_chk(4'h6, 8'd0, "close_edge_live");
    rd_chk(4'h5, 8'h05, "close_edge_status");

    // Shrinking WINDOW below WCNT closes on the next cycle
    wr(4'h1, 8'd50);
    wr(4'h0, 8'h03);
    run(10);
    wr(4'h1, 8'd2);
    uo_chk(8'h00, "shrink_before");
    cyc();
    uo_chk(8'h02, "shrink_close");

    // Edge latency, then EN=0 freezes counting
    wr(4'h1, 8'd19);
    spk_period = 4; spk_ph = 0;
    wr(4'h0, 8'h03);
    run(2);
    uo_chk(8'h00, "edge_lat_before");
    rd_chk(4'h6, 8'd0, "live_before_edge");
    cyc();
    uo_chk(8'h04, "edge_lat_pulse");
    rd_chk(4'h6, 8'd1, "live_after_edge");
    run(6);
    wr(4'h0, 8'h00);
    rd_chk(4'h6, 8'd2, "live_frozen_a");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(); #1;
      if (bus_i.uo_out[1]) pulses++;
    end
    chk("no_pulse_when_off", pulses, 0);
    rd_chk(4'h6, 8'd2, "live_frozen_b");
    wr(4'h0, 8'h01);
    run(9);
    uo_chk(8'h00, "resume_before_close");
    cyc();
    #1;
    chk("resume_close", {31'b0, bus_i.uo_out[1]}, 1);
    rd_chk(4'h3, 8'd4, "rate_resume");

    // CLR mid-window
    run(5);
    wr(4'h0, 8'h03);
    rd_chk(4'h3, 8'd0, "clr_rate");
    rd_chk(4'h4, 8'd0, "clr_isi");
    rd_chk(4'h6, 8'd0, "clr_live");
    rd_chk(4'h5, 8'h00, "clr_status");
    rd_chk(4'h1, 8'd19, "clr_window_kept");
    rd_chk(4'h2, 8'd6, "clr_thresh_kept");
    rd_chk(4'h0, 8'h01, "clr_ctrl");

    // VALID write-1-to-clear, and close outranking it
    spk_period = 0; spk_level = 0;
    run(4);
    wr(4'h1, 8'd4);
    wr(4'h0, 8'h03);
    run(5);
    rd_chk(4'h5, 8'h01, "valid_set");
    wr(4'h5, 8'h01);
    rd_chk(4'h5, 8'h00, "valid_w1c");
    run(3);
    wr(4'h5, 8'h01);
    rd_chk(4'h5, 8'h01, "valid_set_wins");

    // ISI: spikes 37 cycles apart, then a 300-cycle gap
    wr(4'h0, 8'h03);
    spk_period = 37; spk_ph = 0;
    run(20);
    rd_chk(4'h4, 8'd0, "isi_first_edge");
    rd_chk(4'h5, 8'h05, "isi_armed");
    run(40);
    rd_chk(4'h4, 8'd37, "isi37_a");
    run(37);
    rd_chk(4'h4, 8'd37, "isi37_b");
    spk_period = 0; spk_level = 0;
    run(300);
    spk_level = 1;
    cyc();
    spk_level = 0;
    run(5);
    rd_chk(4'h4, 8'd255, "isi_saturated");

    // Reset mid-window discards everything
    spk_period = 4; spk_ph = 0;
    run(13);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    check_reset_values("midreset");
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
